// File: rtl/dmux_frame_tx_if.sv
// Upstream word port of dmux_frame_tx: one DW-bit word plus a 4-bit
// destination channel, transferred over a valid/ready handshake.
//
// Handshake: the source raises in_valid with in_data/in_dest stable; a word
// is transferred on every rising clk edge where in_valid and in_ready are
// both 1. The source keeps valid/data/dest unchanged until that edge, and
// in_ready never depends on in_valid.
interface dmux_frame_tx_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [3:0]    in_dest;

    modport master (output in_valid, output in_data, output in_dest, input in_ready);
    modport slave  (input in_valid, input in_data, input in_dest, output in_ready);
endinterface

// File: rtl/dmux_frame_tx.sv
// dmux_frame_tx: serialising frame scheduler driving demux_1x16 (i, s).
// An accepted word goes out MSB-first on i while s holds the destination;
// masked destinations are dropped with a one-cycle drop pulse; GAP idle
// cycles follow every frame.
// Optional feature: define DMX_PARITY_EN to append an even-parity bit to
// every frame (frame becomes DW+1 bits, done one cycle later).
//
// Timing (accept on edge N): the first bit is driven by edge N itself, so
// the word's MSB is on i during the cycle that ends at edge N+1 and bit 0
// during the cycle that ends at edge N+DW. done follows the last frame bit,
// then in_ready returns after GAP further cycles (back-to-back spacing with
// GAP=0 and no parity is DW+2 cycles per word).
module dmux_frame_tx #(
    parameter int DW  = 8,
    parameter int GAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmux_frame_tx_if.slave    up,
    input  logic [15:0]       mask,
    output logic              i,
    output logic [3:0]        s,
    output logic              frame,
    output logic              done,
    output logic              drop,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_PAR   = 3'd2,
        ST_END   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int             CW       = $clog2(DW + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DW);
    localparam logic [3:0]     GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    state_t        state;
    logic [DW-1:0] shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    gcnt;
`ifdef DMX_PARITY_EN
    logic          par_q;
`endif

    // Ready only in IDLE and forced low while reset is held.
    assign up.in_ready = (state == ST_IDLE) & ~rst;
    assign state_dbg   = state;

    // Frame FSM with registered serial outputs; done/drop are one-cycle pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            gcnt  <= '0;
            i     <= 1'b0;
            s     <= 4'd0;
            frame <= 1'b0;
            done  <= 1'b0;
            drop  <= 1'b0;
`ifdef DMX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (up.in_valid) begin
                        if (!mask[up.in_dest]) begin
                            // Masked channel: consume the word, leave i/s/frame alone.
                            drop <= 1'b1;
                        end else begin
                            // MSB goes straight onto i; shreg keeps the remaining bits.
                            i     <= up.in_data[DW-1];
                            frame <= 1'b1;
                            s     <= up.in_dest;
                            shreg <= {up.in_data[DW-2:0], 1'b0};
                            cnt   <= CW'(1);
`ifdef DMX_PARITY_EN
                            par_q <= ^up.in_data;
`endif
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt == CNT_LAST) begin
`ifdef DMX_PARITY_EN
                        i     <= par_q;
                        state <= ST_PAR;
`else
                        i     <= 1'b0;
                        frame <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_END;
`endif
                    end else begin
                        i     <= shreg[DW-1];
                        shreg <= {shreg[DW-2:0], 1'b0};
                        cnt   <= cnt + CW'(1);
                    end
                end
`ifdef DMX_PARITY_EN
                ST_PAR: begin
                    i     <= 1'b0;
                    frame <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_END;
                end
`endif
                ST_END: begin
                    // done is high during this state; decide whether to idle out a gap.
                    if (GAP > 0) begin
                        gcnt  <= 4'd0;
                        state <= ST_GAP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmux_frame_tx.sv
// Directed bench for dmux_frame_tx. Two instances share clk/rst:
// u_dut1 (GAP=1) and u_dut0 (GAP=0, back-to-back traffic).
// "Cycle N+k" below is the cycle ending at rising edge N+k, observed at the
// falling edge inside it; edge N is the accept edge.
module tb_dmux_frame_tx;
    localparam int DW = 8;
`ifdef DMX_PARITY_EN
    localparam int FLEN = DW + 1;
`else
    localparam int FLEN = DW;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mask1, mask0;
    logic        i1, frame1, done1, drop1;
    logic        i0, frame0, done0, drop0;
    logic [3:0]  s1, s0;
    logic [2:0]  st1, st0;

    int checks   = 0;
    int failures = 0;

    dmux_frame_tx_if #(.DW(DW)) up1 ();
    dmux_frame_tx_if #(.DW(DW)) up0 ();

    dmux_frame_tx #(.DW(DW), .GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .up(up1), .mask(mask1),
        .i(i1), .s(s1), .frame(frame1), .done(done1), .drop(drop1), .state_dbg(st1)
    );

    dmux_frame_tx #(.DW(DW), .GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .up(up0), .mask(mask0),
        .i(i0), .s(s0), .frame(frame0), .done(done0), .drop(drop0), .state_dbg(st0)
    );

    // clock
    always #5 clk = ~clk;

    // Expected serial bit k (0 = first on the wire): MSB-first data, then even parity.
    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < DW) return w[DW-1-k];
        return ^w;
    endfunction

    // driver tasks
    task automatic drive1(input logic [7:0] d, input logic [3:0] dest);
        @(negedge clk);
        up1.in_valid = 1'b1;
        up1.in_data  = d;
        up1.in_dest  = dest;
    endtask

    task automatic drive0(input logic [7:0] d, input logic [3:0] dest);
        @(negedge clk);
        up0.in_valid = 1'b1;
        up0.in_data  = d;
        up0.in_dest  = dest;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (i1 !== 1'b0) begin failures++; $display("FAIL reset_i got=%b exp=0", i1); end
        checks++; if (s1 !== 4'd0) begin failures++; $display("FAIL reset_s got=%h exp=0", s1); end
        checks++; if (frame1 !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame1); end
        checks++; if ({done1, drop1} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {done1, drop1}); end
        checks++; if (up1.in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", up1.in_ready); end
        checks++; if (st1 !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st1); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (up1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", up1.in_ready); end
        checks++; if (up0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready0_after got=%b exp=1", up0.in_ready); end
    endtask

    task automatic test_frame();
        mask1 = 16'hFFFF;
        drive1(8'hA5, 4'hB);
        @(posedge clk);
        for (int k = 1; k <= FLEN + 3; k++) begin
            @(negedge clk);
            if (k == 1) up1.in_valid = 1'b0;
            if (k <= FLEN) begin
                checks++; if (i1 !== exp_bit(8'hA5, k-1)) begin failures++; $display("FAIL frame_i k=%0d got=%b exp=%b", k, i1, exp_bit(8'hA5, k-1)); end
                checks++; if (frame1 !== 1'b1) begin failures++; $display("FAIL frame_frame k=%0d got=%b exp=1", k, frame1); end
                checks++; if (s1 !== 4'hB) begin failures++; $display("FAIL frame_s k=%0d got=%h exp=b", k, s1); end
                checks++; if (up1.in_ready !== 1'b0) begin failures++; $display("FAIL frame_ready k=%0d got=%b exp=0", k, up1.in_ready); end
            end else if (k == FLEN + 1) begin
                checks++; if ({done1, frame1, i1} !== 3'b100) begin failures++; $display("FAIL frame_done got=%b exp=100", {done1, frame1, i1}); end
                checks++; if (up1.in_ready !== 1'b0) begin failures++; $display("FAIL frame_ready_done got=%b exp=0", up1.in_ready); end
            end else if (k == FLEN + 2) begin
                checks++; if ({done1, frame1, i1, up1.in_ready} !== 4'b0000) begin failures++; $display("FAIL frame_gap got=%b exp=0000", {done1, frame1, i1, up1.in_ready}); end
            end else begin
                checks++; if (up1.in_ready !== 1'b1) begin failures++; $display("FAIL frame_ready_back got=%b exp=1", up1.in_ready); end
                checks++; if (s1 !== 4'hB) begin failures++; $display("FAIL frame_s_hold got=%h exp=b", s1); end
            end
        end
    endtask

    task automatic test_drop();
        mask1 = 16'hFFF7;
        drive1(8'h3C, 4'd3);
        @(posedge clk);
        @(negedge clk);
        up1.in_valid = 1'b0;
        checks++; if (drop1 !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", drop1); end
        checks++; if ({frame1, i1} !== 2'b00) begin failures++; $display("FAIL drop_quiet got=%b exp=00", {frame1, i1}); end
        checks++; if (s1 !== 4'hB) begin failures++; $display("FAIL drop_s got=%h exp=b", s1); end
        checks++; if (up1.in_ready !== 1'b1) begin failures++; $display("FAIL drop_ready got=%b exp=1", up1.in_ready); end
        @(negedge clk);
        checks++; if (drop1 !== 1'b0) begin failures++; $display("FAIL drop_width got=%b exp=0", drop1); end
        checks++; if ({up1.in_ready, frame1} !== 2'b10) begin failures++; $display("FAIL drop_after got=%b exp=10", {up1.in_ready, frame1}); end
        mask1 = 16'hFFFF;
    endtask

    task automatic test_hold_inputs();
        drive1(8'hC3, 4'h2);
        @(posedge clk);
        for (int k = 1; k <= FLEN + 3; k++) begin
            @(negedge clk);
            if (k <= FLEN) begin
                up1.in_data = (k % 2 == 1) ? 8'h3C : 8'hFF;
                up1.in_dest = 4'(k);
                checks++; if (i1 !== exp_bit(8'hC3, k-1)) begin failures++; $display("FAIL hold_i k=%0d got=%b exp=%b", k, i1, exp_bit(8'hC3, k-1)); end
                checks++; if (s1 !== 4'h2) begin failures++; $display("FAIL hold_s k=%0d got=%h exp=2", k, s1); end
                checks++; if (up1.in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready k=%0d got=%b exp=0", k, up1.in_ready); end
            end else if (k == FLEN + 1) begin
                up1.in_valid = 1'b0;
                checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL hold_done got=%b exp=1", done1); end
            end else if (k == FLEN + 3) begin
                checks++; if ({up1.in_ready, frame1, s1} !== {2'b10, 4'h2}) begin failures++; $display("FAIL hold_idle got=%b exp=%b", {up1.in_ready, frame1, s1}, {2'b10, 4'h2}); end
            end
        end
    endtask

    // GAP=0 instance: second word held valid; ready returns DW+2 cycles after accept.
    task automatic test_back_to_back();
        mask0 = 16'hFFFF;
        drive0(8'hFF, 4'h0);
        @(posedge clk);
        for (int k = 1; k <= 2*FLEN + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                up0.in_data = 8'h01;
                up0.in_dest = 4'hF;
            end
            if (k <= FLEN) begin
                checks++; if ({frame0, i0, s0} !== {1'b1, exp_bit(8'hFF, k-1), 4'h0}) begin failures++; $display("FAIL b2b_first k=%0d got=%b exp=%b", k, {frame0, i0, s0}, {1'b1, exp_bit(8'hFF, k-1), 4'h0}); end
            end else if (k == FLEN + 1) begin
                checks++; if ({done0, frame0, i0, up0.in_ready} !== 4'b1000) begin failures++; $display("FAIL b2b_done1 got=%b exp=1000", {done0, frame0, i0, up0.in_ready}); end
            end else if (k == FLEN + 2) begin
                checks++; if ({done0, frame0, i0, up0.in_ready} !== 4'b0001) begin failures++; $display("FAIL b2b_ready got=%b exp=0001", {done0, frame0, i0, up0.in_ready}); end
            end else if (k <= 2*FLEN + 2) begin
                if (k == FLEN + 3) up0.in_valid = 1'b0;
                checks++; if ({frame0, i0, s0} !== {1'b1, exp_bit(8'h01, k-FLEN-3), 4'hF}) begin failures++; $display("FAIL b2b_second k=%0d got=%b exp=%b", k, {frame0, i0, s0}, {1'b1, exp_bit(8'h01, k-FLEN-3), 4'hF}); end
            end else begin
                checks++; if ({done0, frame0, i0} !== 3'b100) begin failures++; $display("FAIL b2b_done2 got=%b exp=100", {done0, frame0, i0}); end
            end
        end
        @(negedge clk);
        checks++; if ({done0, up0.in_ready} !== 2'b01) begin failures++; $display("FAIL b2b_idle got=%b exp=01", {done0, up0.in_ready}); end
    endtask

    task automatic test_async_reset();
        drive1(8'hA5, 4'hB);
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) up1.in_valid = 1'b0;
            checks++; if ({frame1, i1} !== {1'b1, exp_bit(8'hA5, k-1)}) begin failures++; $display("FAIL ares_pre k=%0d got=%b exp=%b", k, {frame1, i1}, {1'b1, exp_bit(8'hA5, k-1)}); end
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({i1, frame1, done1} !== 3'b000) begin failures++; $display("FAIL ares_outputs got=%b exp=000", {i1, frame1, done1}); end
        checks++; if (s1 !== 4'd0) begin failures++; $display("FAIL ares_s got=%h exp=0", s1); end
        checks++; if (up1.in_ready !== 1'b0) begin failures++; $display("FAIL ares_ready got=%b exp=0", up1.in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++; if ({done1, frame1} !== 2'b00) begin failures++; $display("FAIL ares_no_done k=%0d got=%b exp=00", k, {done1, frame1}); end
        end
        checks++; if ({up1.in_ready, st1} !== {1'b1, 3'd0}) begin failures++; $display("FAIL ares_idle got=%b exp=%b", {up1.in_ready, st1}, {1'b1, 3'd0}); end
    endtask

    // 8'h07 has odd weight, so the parity bit (when built in) is 1.
    task automatic test_parity();
        drive1(8'h07, 4'h5);
        @(posedge clk);
        for (int k = 1; k <= FLEN + 1; k++) begin
            @(negedge clk);
            if (k == 1) up1.in_valid = 1'b0;
            if (k <= FLEN) begin
                checks++; if ({frame1, i1, s1} !== {1'b1, exp_bit(8'h07, k-1), 4'h5}) begin failures++; $display("FAIL par_bit k=%0d got=%b exp=%b", k, {frame1, i1, s1}, {1'b1, exp_bit(8'h07, k-1), 4'h5}); end
            end else begin
                checks++; if ({done1, frame1, i1} !== 3'b100) begin failures++; $display("FAIL par_done got=%b exp=100", {done1, frame1, i1}); end
            end
        end
        repeat (3) @(negedge clk);
        checks++; if (up1.in_ready !== 1'b1) begin failures++; $display("FAIL par_idle got=%b exp=1", up1.in_ready); end
    endtask

    initial begin
        up1.in_valid = 1'b0; up1.in_data = '0; up1.in_dest = '0;
        up0.in_valid = 1'b0; up0.in_data = '0; up0.in_dest = '0;
        mask1 = 16'hFFFF;
        mask0 = 16'hFFFF;
        test_reset();
        test_frame();
        test_drop();
        test_hold_inputs();
        test_back_to_back();
        test_async_reset();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
